muldiv_ctrl: RTL and testbench
==============================

Name: muldiv_ctrl

Overview:
- Multi-cycle sequencer for the RV32M multiply/divide operations in the EX stage.
- Detects an M-extension aluop, asserts a stall request to hold the pipeline, and runs a 32-iteration shift-add multiply or restoring divide.
- Applies sign fixup, then presents the result for one cycle so EX can mux it into wdata_o.
- Sits beside the ALU in EX; the pipeline control logic consumes stallreq_o.

Parameters:
- XLEN, 32, operand/result width (only 32 supported)
- ITER, 32, iteration count of the RUN state (must equal XLEN)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, synchronous, active-high
- aluop_i  in  8  EX aluop; M-ops are 8'b10100_fff, where fff = funct3 (000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU)
- reg1_i  in  32  rs1 operand (multiplicand/dividend)
- reg2_i  in  32  rs2 operand (multiplier/divisor)
- flush_i  in  1  annul the in-flight op (branch/exception flush)
- stallreq_o  out  1  stall request to pipeline control
- result_valid_o  out  1  result_o valid this cycle
- result_o  out  32  rd write data for the M-op

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset state:
  - FSM goes to IDLE.
  - stallreq_o=0, result_valid_o=0, result_o=0.
  - Iteration counter=0.
  - Internal accumulators/quotient are cleared.
- States: IDLE, RUN, FIXUP, DONE.
- IDLE:
  - When aluop_i[7:3]==5'b10100 and flush_i=0, stallreq_o=1 combinationally in that same cycle.
  - Operands are captured at the next edge. For signed operands, absolute values and sign flags are captured. Signedness per op: MULH both signed; MULHSU rs1 only; DIV/REM both signed; others unsigned.
  - Next state is RUN, counter=0.
- Fast path (divide ops, decided at capture; next state is DONE directly, stallreq high for 1 cycle only):
  - Divisor==0: quotient=32'hFFFFFFFF, remainder=reg1_i.
  - DIV/REM with reg1_i=32'h80000000 and reg2_i=32'hFFFFFFFF: quotient=32'h80000000, remainder=0.
- RUN:
  - stallreq_o=1.
  - One iteration per cycle. Multiply: shift-add into a 64-bit product. Divide: restoring step on the 33-bit partial remainder.
  - Counter increments each cycle. Leave RUN after counter==ITER-1 (32 cycles); next state is FIXUP.
- FIXUP:
  - stallreq_o=1.
  - Multiply: negate the 64-bit product if the sign flags differ.
  - Divide: negate the quotient if the signs differ (signed ops); negate the remainder if the dividend is negative.
  - Select output: MUL low 32 bits; MULH/MULHSU/MULHU high 32 bits; DIV/DIVU quotient; REM/REMU remainder.
  - result_o is registered at the FIXUP→DONE edge.
- DONE:
  - stallreq_o=0 and result_valid_o=1.
  - Pipeline advances at this edge; next state is IDLE unconditionally. The same held aluop is not re-triggered.
- Latency (normal path): op arrives in cycle 0 and stallreq_o is high in cycles 0..33 (34 cycles). result_valid_o is high in cycle 34.
- Latency (fast path): stallreq_o is high in cycle 0 only; result_valid_o is high in cycle 1.
- result_o holds its last value outside DONE. result_valid_o is the qualifier.
- Flush:
  - flush_i=1 in any state forces IDLE at the next edge. No result_valid_o pulse is produced.
  - stallreq_o is forced 0 combinationally while flush_i=1.
  - flush in DONE suppresses result_valid_o that cycle.
- Reset priority: rst mid-operation overrides everything, including flush, and returns all outputs to reset values at the next edge.
- Input stability: aluop_i/reg*_i changing while in RUN/FIXUP is ignored; the captured operands are used.
- Back-to-back M-ops: the second op is seen in the IDLE cycle after DONE and starts normally.
- Non-M aluop in IDLE: stallreq_o=0 and the FSM stays in IDLE.

Decomposition:
- Shared defines include, holding:
  - the M-op aluop constants (8'b10100000..8'b10100111)
  - the MUL_PREFIX 5'b10100
  - the FSM state encodings (2-bit)
  - the constant DIV_BY_ZERO_Q = 32'hFFFFFFFF
- One natural sub-module, muldiv_step: combinational single iteration (shift-add or restore-subtract) on {acc, op, mode}. The controller instantiates it once.

Test Plan:
- MUL reg1=7, reg2=32'hFFFFFFFD → stallreq_o high for exactly 34 cycles, then result_valid_o=1 with result_o=32'hFFFFFFEB.
- MULHU 32'hFFFFFFFF×32'hFFFFFFFF → 32'hFFFFFFFE. MULH of the same operands → 0. MULHSU 32'hFFFFFFFF×2 → 32'hFFFFFFFF.
- DIV −7/2 → 32'hFFFFFFFD. REM −7/2 → 32'hFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2.
- DIVU 5/0 → 32'hFFFFFFFF and REMU 5/0 → 5. DIV 32'h80000000/−1 → 32'h80000000 and REM → 0. Each of these has 1 stall cycle, then valid.
- flush_i pulsed at RUN cycle 10 → FSM is IDLE next cycle, stallreq_o=0, no result_valid_o. The following MUL 3×4 → 12 after the full 34-cycle stall.
- rst asserted at RUN cycle 20 → next cycle all outputs 0 and IDLE. Two back-to-back MULs (2×3, 4×5) → results 6 and 20, with valid pulses 35 cycles apart.

Source files
------------

// File: rtl/muldiv_ctrl_pkg.sv
// Shared constants and types for the RV32M multiply/divide sequencer.
package muldiv_ctrl_pkg;

    localparam logic [4:0] MUL_PREFIX = 5'b10100;

    localparam logic [7:0] ALUOP_MUL    = 8'b10100_000;
    localparam logic [7:0] ALUOP_MULH   = 8'b10100_001;
    localparam logic [7:0] ALUOP_MULHSU = 8'b10100_010;
    localparam logic [7:0] ALUOP_MULHU  = 8'b10100_011;
    localparam logic [7:0] ALUOP_DIV    = 8'b10100_100;
    localparam logic [7:0] ALUOP_DIVU   = 8'b10100_101;
    localparam logic [7:0] ALUOP_REM    = 8'b10100_110;
    localparam logic [7:0] ALUOP_REMU   = 8'b10100_111;

    localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFFFFFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_FIXUP = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

    function automatic logic is_m_op(input logic [7:0] aluop);
        return aluop[7:3] == MUL_PREFIX;
    endfunction

    // MULH, MULHSU, DIV and REM treat rs1 as signed.
    function automatic logic rs1_signed(input logic [2:0] f3);
        return (f3 == ALUOP_MULH[2:0]) || (f3 == ALUOP_MULHSU[2:0]) ||
               (f3 == ALUOP_DIV[2:0])  || (f3 == ALUOP_REM[2:0]);
    endfunction

    function automatic logic rs2_signed(input logic [2:0] f3);
        return (f3 == ALUOP_MULH[2:0]) || (f3 == ALUOP_DIV[2:0]) ||
               (f3 == ALUOP_REM[2:0]);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply step or restoring divide step.
module muldiv_step
    import muldiv_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic              div_mode_i,
    input  logic [2*XLEN-1:0] acc_i,
    input  logic [XLEN-1:0]   opnd_i,
    output logic [2*XLEN-1:0] acc_o
);

    logic [XLEN:0]   sum;
    logic [XLEN:0]   rem_shift;
    logic [XLEN-1:0] diff;
    logic            fits;

    // Multiply: acc = {partial product high, remaining multiplier bits}.
    // Divide:   acc = {partial remainder, dividend bits becoming quotient}.
    always_comb begin
        sum       = {1'b0, acc_i[2*XLEN-1:XLEN]} + {1'b0, opnd_i};
        rem_shift = {acc_i[2*XLEN-1:XLEN], acc_i[XLEN-1]};
        fits      = rem_shift >= {1'b0, opnd_i};
        diff      = rem_shift[XLEN-1:0] - opnd_i;
        acc_o     = '0;
        if (div_mode_i) begin
            if (fits) begin
                acc_o = {diff, acc_i[XLEN-2:0], 1'b1};
            end else begin
                acc_o = {rem_shift[XLEN-1:0], acc_i[XLEN-2:0], 1'b0};
            end
        end else begin
            if (acc_i[0]) begin
                acc_o = {sum, acc_i[XLEN-1:1]};
            end else begin
                acc_o = {1'b0, acc_i[2*XLEN-1:1]};
            end
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// RV32M multiply/divide sequencer for EX: stalls the pipeline while a 32-iteration
// multiply or divide runs on magnitudes, fixes up signs, then presents rd data for one cycle.
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [7:0]      aluop_i,
    input  logic [XLEN-1:0] reg1_i,
    input  logic [XLEN-1:0] reg2_i,
    input  logic            flush_i,
    output logic            stallreq_o,
    output logic            result_valid_o,
    output logic [XLEN-1:0] result_o
);

    localparam int CNT_W = $clog2(ITER);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        f3_q, f3_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [2*XLEN-1:0] acc_q, acc_d, step_acc;
    logic              neg_a_q, neg_a_d, neg_b_q, neg_b_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic [2:0]        f3_in;
    logic              in_div, in_rem, neg_a_in, neg_b_in, fast_zero, fast_ovf;
    logic [XLEN-1:0]   abs_a, abs_b, fast_res;

    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_fix, rem_fix, fix_res;

    muldiv_step #(.XLEN(XLEN)) u_step (
        .div_mode_i (f3_q[2]),
        .acc_i      (acc_q),
        .opnd_i     (opnd_q),
        .acc_o      (step_acc)
    );

    // Capture-time decode: magnitudes, sign flags and the divide shortcuts.
    always_comb begin
        f3_in     = aluop_i[2:0];
        in_div    = f3_in[2];
        in_rem    = f3_in[2] & f3_in[1];
        neg_a_in  = rs1_signed(f3_in) & reg1_i[XLEN-1];
        neg_b_in  = rs2_signed(f3_in) & reg2_i[XLEN-1];
        abs_a     = neg_a_in ? -reg1_i : reg1_i;
        abs_b     = neg_b_in ? -reg2_i : reg2_i;
        fast_zero = in_div & (reg2_i == '0);
        fast_ovf  = in_div & rs2_signed(f3_in) & (reg1_i == INT_MIN) & (reg2_i == '1);
        if (fast_zero) begin
            fast_res = in_rem ? reg1_i : DIV_BY_ZERO_Q;
        end else begin
            fast_res = in_rem ? '0 : INT_MIN;
        end
    end

    always_comb begin
        prod_fix = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
        quot_fix = (neg_a_q ^ neg_b_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem_fix  = neg_a_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        case (f3_q)
            ALUOP_MUL[2:0]:                                      fix_res = prod_fix[XLEN-1:0];
            ALUOP_MULH[2:0], ALUOP_MULHSU[2:0], ALUOP_MULHU[2:0]: fix_res = prod_fix[2*XLEN-1:XLEN];
            ALUOP_DIV[2:0], ALUOP_DIVU[2:0]:                     fix_res = quot_fix;
            default:                                             fix_res = rem_fix;
        endcase
    end

    // Flush wins over every state and also masks both outputs in the same cycle.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        f3_d           = f3_q;
        opnd_d         = opnd_q;
        acc_d          = acc_q;
        neg_a_d        = neg_a_q;
        neg_b_d        = neg_b_q;
        result_d       = result_q;
        stallreq_o     = 1'b0;
        result_valid_o = 1'b0;
        if (flush_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (is_m_op(aluop_i)) begin
                        stallreq_o = 1'b1;
                        f3_d       = f3_in;
                        neg_a_d    = neg_a_in;
                        neg_b_d    = neg_b_in;
                        cnt_d      = '0;
                        opnd_d     = in_div ? abs_b : abs_a;
                        acc_d      = {{XLEN{1'b0}}, (in_div ? abs_a : abs_b)};
                        if (fast_zero || fast_ovf) begin
                            result_d = fast_res;
                            state_d  = ST_DONE;
                        end else begin
                            state_d  = ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    stallreq_o = 1'b1;
                    acc_d      = step_acc;
                    cnt_d      = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(ITER - 1)) begin
                        state_d = ST_FIXUP;
                    end
                end
                ST_FIXUP: begin
                    stallreq_o = 1'b1;
                    result_d   = fix_res;
                    state_d    = ST_DONE;
                end
                default: begin
                    result_valid_o = 1'b1;
                    state_d        = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            f3_q     <= '0;
            opnd_q   <= '0;
            acc_q    <= '0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            f3_q     <= f3_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            result_q <= result_d;
        end
    end

    assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: expected rd data is queued at issue and popped at result_valid_o.
module tb_muldiv_ctrl;
    import muldiv_ctrl_pkg::*;

    localparam logic [7:0] NOP = 8'h00;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  aluop_i = NOP;
    logic [31:0] reg1_i = '0;
    logic [31:0] reg2_i = '0;
    logic        flush_i = 1'b0;
    logic        stallreq_o;
    logic        result_valid_o;
    logic [31:0] result_o;

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    logic [31:0] exp_q[$];

    muldiv_ctrl #(.XLEN(32), .ITER(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .aluop_i        (aluop_i),
        .reg1_i         (reg1_i),
        .reg2_i         (reg2_i),
        .flush_i        (flush_i),
        .stallreq_o     (stallreq_o),
        .result_valid_o (result_valid_o),
        .result_o       (result_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Independent reference built on 64-bit SystemVerilog arithmetic.
    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] b);
        logic signed [63:0] sa, sb, ubs;
        logic [63:0]        ua, ub, p;
        logic signed [31:0] q;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        ua  = {32'h0, a};
        ub  = {32'h0, b};
        ubs = ub;
        p   = '0;
        q   = '0;
        case (f3)
            3'b000:  p = ua * ub;
            3'b001:  p = sa * sb;
            3'b010:  p = sa * ubs;
            3'b011:  p = ua * ub;
            default: p = '0;
        endcase
        if (!f3[2]) return (f3 == 3'b000) ? p[31:0] : p[63:32];
        if (b == 32'h0) return f3[1] ? a : 32'hFFFFFFFF;
        if (!f3[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return f3[1] ? 32'h0 : 32'h80000000;
        case (f3)
            3'b100:  q = $signed(a) / $signed(b);
            3'b101:  return a / b;
            3'b110:  q = $signed(a) % $signed(b);
            default: return a % b;
        endcase
        return q;
    endfunction

    // Starts at a negedge, holds the op until result_valid_o, returns at the following negedge.
    task automatic issue_op(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                            input bit scramble, output int stalls, output bit seen,
                            output logic [31:0] res, output int vcyc);
        aluop_i = op;
        reg1_i  = a;
        reg2_i  = b;
        stalls  = 0;
        seen    = 1'b0;
        res     = '0;
        vcyc    = -1;
        for (int c = 0; c < 60 && !seen; c++) begin
            #1;
            if (stallreq_o === 1'b1) stalls++;
            if (result_valid_o === 1'b1) begin
                seen = 1'b1;
                res  = result_o;
                vcyc = cyc;
            end
            @(negedge clk);
            if (scramble && !seen) begin
                reg1_i = $urandom;
                reg2_i = $urandom;
            end
        end
        aluop_i = NOP;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        vectors++;
        if (stallreq_o !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_stall: got %b expected 0", stallreq_o);
        end
        vectors++;
        if (result_valid_o !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_valid: got %b expected 0", result_valid_o);
        end
        vectors++;
        if (result_o !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_result: got %h expected 00000000", result_o);
        end
        @(negedge clk);
    endtask

    // Table-driven ops with their expected stall length; popped from the scoreboard on valid.
    task automatic run_table(input string tag, input logic [7:0] ops[], input logic [31:0] as[],
                             input logic [31:0] bs[], input logic [31:0] exps[],
                             input int exp_stalls, input bit scramble);
        int stalls, vcyc;
        bit seen;
        logic [31:0] res, exp;
        for (int i = 0; i < ops.size(); i++) begin
            exp_q.push_back(exps[i]);
            issue_op(ops[i], as[i], bs[i], scramble, stalls, seen, res, vcyc);
            exp = exp_q.pop_front();
            vectors++;
            if (!seen || res !== exp) begin
                miscompares++;
                $display("[TB] FAIL %s[%0d] result: got %h (valid seen %b) expected %h",
                         tag, i, res, seen, exp);
            end
            vectors++;
            if (stalls != exp_stalls) begin
                miscompares++;
                $display("[TB] FAIL %s[%0d] stall cycles: got %0d expected %0d",
                         tag, i, stalls, exp_stalls);
            end
        end
    endtask

    task automatic test_mul;
        int stalls, vcyc, start;
        bit seen;
        logic [31:0] res, exp;
        start = cyc;
        exp_q.push_back(32'hFFFFFFEB);
        issue_op(ALUOP_MUL, 32'd7, 32'hFFFFFFFD, 1'b0, stalls, seen, res, vcyc);
        exp = exp_q.pop_front();
        vectors++;
        if (!seen || res !== exp) begin
            miscompares++;
            $display("[TB] FAIL mul_result: got %h expected %h", res, exp);
        end
        vectors++;
        if (stalls != 34) begin
            miscompares++;
            $display("[TB] FAIL mul_stall: got %0d expected 34", stalls);
        end
        vectors++;
        if (vcyc - start != 34) begin
            miscompares++;
            $display("[TB] FAIL mul_latency: got %0d expected 34", vcyc - start);
        end
    endtask

    task automatic test_mulh;
        run_table("mulh", '{ALUOP_MULHU, ALUOP_MULH, ALUOP_MULHSU},
                  '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF},
                  '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2},
                  '{32'hFFFFFFFE, 32'h0, 32'hFFFFFFFF}, 34, 1'b0);
    endtask

    task automatic test_div;
        run_table("div", '{ALUOP_DIV, ALUOP_REM, ALUOP_DIVU, ALUOP_REMU},
                  '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100},
                  '{32'd2, 32'd2, 32'd7, 32'd7},
                  '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2}, 34, 1'b1);
    endtask

    task automatic test_fast_path;
        run_table("fast", '{ALUOP_DIVU, ALUOP_REMU, ALUOP_DIV, ALUOP_REM, ALUOP_DIV, ALUOP_REM},
                  '{32'd5, 32'd5, 32'h80000000, 32'h80000000, 32'hFFFFFFF7, 32'hFFFFFFF7},
                  '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0},
                  '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFF7},
                  1, 1'b1);
    endtask

    task automatic test_flush;
        int noise;
        aluop_i = ALUOP_MUL;
        reg1_i  = 32'd9;
        reg2_i  = 32'd9;
        repeat (11) @(negedge clk);
        flush_i = 1'b1;
        #1;
        vectors++;
        if (stallreq_o !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL flush_stall_masked: got %b expected 0", stallreq_o);
        end
        @(negedge clk);
        flush_i = 1'b0;
        aluop_i = NOP;
        noise   = 0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (stallreq_o !== 1'b0 || result_valid_o !== 1'b0) noise++;
            @(negedge clk);
        end
        vectors++;
        if (noise != 0) begin
            miscompares++;
            $display("[TB] FAIL flush_idle: got %0d busy cycles expected 0", noise);
        end
        run_table("after_flush", '{ALUOP_MUL}, '{32'd3}, '{32'd4}, '{32'd12}, 34, 1'b0);
    endtask

    task automatic test_flush_done;
        aluop_i = ALUOP_DIVU;
        reg1_i  = 32'd50;
        reg2_i  = 32'd5;
        repeat (34) @(negedge clk);
        #1;
        vectors++;
        if (result_valid_o !== 1'b1 || result_o !== 32'd10) begin
            miscompares++;
            $display("[TB] FAIL done_before_flush: got valid %b data %h expected 1 0000000a",
                     result_valid_o, result_o);
        end
        flush_i = 1'b1;
        #1;
        vectors++;
        if (result_valid_o !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL flush_in_done: got %b expected 0", result_valid_o);
        end
        @(negedge clk);
        flush_i = 1'b0;
        aluop_i = NOP;
        #1;
        vectors++;
        if (result_valid_o !== 1'b0 || stallreq_o !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL after_flush_done: got valid %b stall %b expected 0 0",
                     result_valid_o, stallreq_o);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int noise;
        aluop_i = ALUOP_MUL;
        reg1_i  = 32'd11;
        reg2_i  = 32'd13;
        repeat (21) @(negedge clk);
        rst     = 1'b1;
        flush_i = 1'b1;
        aluop_i = NOP;
        @(negedge clk);
        rst     = 1'b0;
        flush_i = 1'b0;
        #1;
        vectors++;
        if (stallreq_o !== 1'b0 || result_valid_o !== 1'b0 || result_o !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_mid: got stall %b valid %b data %h expected 0 0 00000000",
                     stallreq_o, result_valid_o, result_o);
        end
        noise = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            #1;
            if (stallreq_o !== 1'b0 || result_valid_o !== 1'b0) noise++;
        end
        vectors++;
        if (noise != 0) begin
            miscompares++;
            $display("[TB] FAIL reset_mid_idle: got %0d busy cycles expected 0", noise);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int stalls, v1, v2;
        bit seen1, seen2;
        logic [31:0] r1, r2, e1, e2;
        exp_q.push_back(32'd6);
        issue_op(ALUOP_MUL, 32'd2, 32'd3, 1'b0, stalls, seen1, r1, v1);
        exp_q.push_back(32'd20);
        issue_op(ALUOP_MUL, 32'd4, 32'd5, 1'b0, stalls, seen2, r2, v2);
        e1 = exp_q.pop_front();
        e2 = exp_q.pop_front();
        vectors++;
        if (!seen1 || r1 !== e1) begin
            miscompares++;
            $display("[TB] FAIL b2b_first: got %h expected %h", r1, e1);
        end
        vectors++;
        if (!seen2 || r2 !== e2) begin
            miscompares++;
            $display("[TB] FAIL b2b_second: got %h expected %h", r2, e2);
        end
        vectors++;
        if (v2 - v1 != 35) begin
            miscompares++;
            $display("[TB] FAIL b2b_spacing: got %0d expected 35", v2 - v1);
        end
        repeat (3) @(negedge clk);
        #1;
        vectors++;
        if (result_o !== 32'd20 || result_valid_o !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL result_hold: got data %h valid %b expected 00000014 0",
                     result_o, result_valid_o);
        end
        @(negedge clk);
    endtask

    task automatic test_random;
        int stalls, vcyc, exp_stalls;
        bit seen;
        logic [2:0]  f3;
        logic [31:0] a, b, res, exp;
        for (int i = 0; i < 12; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
            exp_stalls = (f3[2] && (b == 32'h0 ||
                          (!f3[0] && a == 32'h80000000 && b == 32'hFFFFFFFF))) ? 1 : 34;
            exp_q.push_back(ref_result(f3, a, b));
            issue_op({MUL_PREFIX, f3}, a, b, 1'b1, stalls, seen, res, vcyc);
            exp = exp_q.pop_front();
            vectors++;
            if (!seen || res !== exp || stalls != exp_stalls) begin
                miscompares++;
                $display("[TB] FAIL random[%0d] f3=%0d a=%h b=%h: got %h/%0d stalls expected %h/%0d",
                         i, f3, a, b, res, stalls, exp, exp_stalls);
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        $display("[TB] starting muldiv_ctrl bench");
        test_reset();
        test_mul();
        test_mulh();
        test_div();
        test_fast_path();
        test_flush();
        test_flush_done();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
